mac_accum_seq: RTL and testbench

Sequencer and accumulator front-end for the combinational packed MAC/adder datapath. Accepts one job: mode, beat count and 128-bit bias. Then streams K packed operand pairs into the MAC, holding the 128-bit accumulator in its own register and feeding it back as the addend each beat. Presents the finished packed accumulator on a valid/ready result port. Sits between the tile operand fetch and the writeback stage; it is the initiator that drives the MAC datapath and owns the accumulator register the MAC deliberately leaves outside.

---
 rtl/mac_accum_seq.sv | 124 ++++++++++++
 tb/tb_mac_accum_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_seq.sv
// Job sequencer and 128-bit accumulator owner for the combinational packed MAC datapath.
// Define MAC_ACC_SEQ_ABORT_EN to add the `abort` input (cancels a job in RUN or DONE).
module mac_accum_seq #(
   parameter int unsigned K_MAX = 16,
   parameter int unsigned LEN_W = $clog2(K_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             cfg_mode,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [127:0]     cfg_bias,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   output logic [31:0]      mac_in1,
   output logic [31:0]      mac_in2,
   output logic [127:0]     mac_in3,
   output logic             mac_mode,
   input  logic [127:0]     mac_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [127:0]     res_data,
   output logic             res_mode
`ifdef MAC_ACC_SEQ_ABORT_EN
   ,
   input  logic             abort
`endif
);

   localparam int unsigned ACC_W = 128;
   localparam int unsigned OP_W  = 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] len_clamp;
   logic             mode_q, mode_d;
   logic             abort_hit;

`ifdef MAC_ACC_SEQ_ABORT_EN
   assign abort_hit = abort && (state_q != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign len_clamp = (32'(cfg_len) > K_MAX) ? LEN_W'(K_MAX) : cfg_len;

   // State and accumulator registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state, accumulator update and MAC operand steering
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      mode_d  = mode_q;
      mac_in1 = '0;
      mac_in2 = '0;

      unique case (state_q)
         IDLE: begin
            if (start_valid) begin
               mode_d  = cfg_mode;
               len_d   = len_clamp;
               acc_d   = cfg_bias;
               cnt_d   = '0;
               state_d = (len_clamp == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (op_valid) begin
               mac_in1 = op_a;
               mac_in2 = op_b;
               acc_d   = mac_out;
               cnt_d   = cnt_q + LEN_W'(1);
               if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides any beat or result handshake in the same cycle
      if (abort_hit) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         mac_in1 = OP_W'(0);
         mac_in2 = OP_W'(0);
      end
   end

   assign start_ready = (state_q == IDLE);
   assign op_ready    = (state_q == RUN);
   assign res_valid   = (state_q == DONE);
   assign res_data    = acc_q;
   assign res_mode    = mode_q;
   assign mac_in3     = acc_q;
   assign mac_mode    = mode_q;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Randomized bench for mac_accum_seq: lane-level MAC model as environment, job-level expected sums.
module tb_mac_accum_seq;

   localparam int unsigned K_MAX = 16;
   localparam int unsigned LEN_W = $clog2(K_MAX + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             start_valid, start_ready;
   logic             cfg_mode;
   logic [LEN_W-1:0] cfg_len;
   logic [127:0]     cfg_bias;
   logic             op_valid, op_ready;
   logic [31:0]      op_a, op_b;
   logic [31:0]      mac_in1, mac_in2;
   logic [127:0]     mac_in3;
   logic             mac_mode;
   logic [127:0]     mac_out;
   logic             res_valid, res_ready;
   logic [127:0]     res_data;
   logic             res_mode;
`ifdef MAC_ACC_SEQ_ABORT_EN
   logic             abort;
`endif

   int total = 0;
   int bad   = 0;

   mac_accum_seq #(.K_MAX(K_MAX)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .cfg_mode   (cfg_mode),
      .cfg_len    (cfg_len),
      .cfg_bias   (cfg_bias),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .mac_in1    (mac_in1),
      .mac_in2    (mac_in2),
      .mac_in3    (mac_in3),
      .mac_mode   (mac_mode),
      .mac_out    (mac_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_mode   (res_mode)
`ifdef MAC_ACC_SEQ_ABORT_EN
      ,
      .abort      (abort)
`endif
   );

   always #5 clk = ~clk;

   // Packed signed lane multiply-add: 4x INT8 into 32-bit lanes or 8x INT4 into 16-bit lanes
   function automatic logic [127:0] lane_mac(input logic mode, input logic [127:0] acc,
                                             input logic [31:0] a, input logic [31:0] b);
      logic [127:0]      r;
      logic signed [7:0] a8, b8;
      logic signed [3:0] a4, b4;
      int                pa, pb;
      r = acc;
      if (mode) begin
         for (int i = 0; i < 4; i++) begin
            a8 = a[8*i +: 8];
            b8 = b[8*i +: 8];
            pa = a8;
            pb = b8;
            r[32*i +: 32] = acc[32*i +: 32] + 32'(pa * pb);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            a4 = a[4*i +: 4];
            b4 = b[4*i +: 4];
            pa = a4;
            pb = b4;
            r[16*i +: 16] = acc[16*i +: 16] + 16'(pa * pb);
         end
      end
      return r;
   endfunction

   always_comb mac_out = lane_mac(mac_mode, mac_in3, mac_in1, mac_in2);

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_start_ready"}, 128'(start_ready), 128'(1'b1));
      chk({tag, "_op_ready"},    128'(op_ready),    128'(1'b0));
      chk({tag, "_res_valid"},   128'(res_valid),   128'(1'b0));
      chk({tag, "_res_data"},    res_data,          128'(0));
      chk({tag, "_res_mode"},    128'(res_mode),    128'(1'b0));
      chk({tag, "_mac_in1"},     128'(mac_in1),     128'(0));
      chk({tag, "_mac_in2"},     128'(mac_in2),     128'(0));
      chk({tag, "_mac_in3"},     mac_in3,           128'(0));
      chk({tag, "_mac_mode"},    128'(mac_mode),    128'(1'b0));
   endtask

   // stall: 0 = op_valid always high, 1 = toggle 1/0, 2 = random
   task automatic run_job(input logic mode, input int len, input logic [127:0] bias,
                          input int stall, input int rr_delay, input bit fixed,
                          input logic [31:0] fa, input logic [31:0] fb,
                          output logic [127:0] got);
      logic [127:0] exp;
      logic [31:0]  a, b;
      int           eff, n, guard;
      exp = bias;
      eff = (len > int'(K_MAX)) ? int'(K_MAX) : len;
      chk("idle_start_ready", 128'(start_ready), 128'(1'b1));
      cfg_mode    = mode;
      cfg_len     = LEN_W'(len);
      cfg_bias    = bias;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      cfg_bias    = rand128();
      n = 0;
      guard = 0;
      while (n < eff && guard < 4 * int'(K_MAX) + 8) begin
         case (stall)
            0:       op_valid = 1'b1;
            1:       op_valid = (guard % 2 == 0);
            default: op_valid = 1'($urandom_range(0, 1));
         endcase
         a    = fixed ? fa : $urandom();
         b    = fixed ? fb : $urandom();
         op_a = a;
         op_b = b;
         #1;
         chk("run_op_ready", 128'(op_ready), 128'(1'b1));
         chk("run_start_ready", 128'(start_ready), 128'(1'b0));
         chk("run_res_valid", 128'(res_valid), 128'(1'b0));
         chk("run_mac_in3", mac_in3, exp);
         chk("run_mac_mode", 128'(mac_mode), 128'(mode));
         chk("run_mac_in1", 128'(mac_in1), 128'(op_valid ? a : 32'h0));
         chk("run_mac_in2", 128'(mac_in2), 128'(op_valid ? b : 32'h0));
         if (op_valid) begin
            exp = lane_mac(mode, exp, a, b);
            n++;
         end
         step();
         guard++;
      end
      op_valid = 1'b0;
      op_a     = '0;
      op_b     = '0;
      if (n < eff) chk("beat_timeout", 128'(n), 128'(eff));
      chk("done_res_valid", 128'(res_valid), 128'(1'b1));
      chk("done_op_ready", 128'(op_ready), 128'(1'b0));
      for (int d = 0; d < rr_delay; d++) begin
         res_ready   = 1'b0;
         start_valid = 1'b1;
         cfg_len     = LEN_W'($urandom_range(0, 31));
         #1;
         chk("hold_res_valid", 128'(res_valid), 128'(1'b1));
         chk("hold_res_data", res_data, exp);
         chk("hold_start_ready", 128'(start_ready), 128'(1'b0));
         step();
      end
      start_valid = 1'b0;
      got = res_data;
      chk("res_data", res_data, exp);
      chk("res_mode", 128'(res_mode), 128'(mode));
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("after_res_start_ready", 128'(start_ready), 128'(1'b1));
      chk("after_res_valid", 128'(res_valid), 128'(1'b0));
   endtask

   task automatic partial_job(input logic [127:0] bias);
      cfg_mode    = 1'b1;
      cfg_len     = LEN_W'(4);
      cfg_bias    = bias;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         op_valid = 1'b1;
         op_a     = $urandom();
         op_b     = $urandom();
         step();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] got, bias;
      rst = 1'b1; start_valid = 1'b0; cfg_mode = 1'b0; cfg_len = '0; cfg_bias = '0;
      op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
`ifdef MAC_ACC_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      step();
      step();
      rst = 1'b0;
      chk_reset_outputs("reset");

      run_job(1'b1, 2, 128'(0), 0, 0, 1'b1, 32'h02020202, 32'h03030303, got);
      chk("int8_const", got, {4{32'h0000000C}});

      run_job(1'b0, 1, 128'(0), 0, 0, 1'b1, 32'hFFFFFFFF, 32'h11111111, got);
      chk("int4_const", got, {4{32'hFFFFFFFF}});

      run_job(1'b1, 0, 128'h1234, 0, 2, 1'b0, 32'h0, 32'h0, got);
      chk("len0_bias", got, 128'h1234);

      bias = {rand128() >> 32, 32'h7FFFFFFF};
      run_job(1'b1, 1, bias, 0, 0, 1'b1, 32'h00000001, 32'h00000001, got);
      chk("wrap_lane0", 128'(got[31:0]), 128'(32'h80000000));
      chk("wrap_upper", 128'(got[127:32]), 128'(bias[127:32]));

      run_job(1'($urandom_range(0, 1)), 4, rand128(), 1, 5, 1'b0, 32'h0, 32'h0, got);

      partial_job(rand128());
      op_valid = 1'b1;
      rst      = 1'b1;
      step();
      rst      = 1'b0;
      op_valid = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      run_job(1'b1, 3, rand128(), 0, 1, 1'b0, 32'h0, 32'h0, got);

`ifdef MAC_ACC_SEQ_ABORT_EN
      partial_job(rand128());
      op_valid = 1'b1;
      abort    = 1'b1;
      step();
      abort    = 1'b0;
      op_valid = 1'b0;
      #1;
      chk("abort_run_start_ready", 128'(start_ready), 128'(1'b1));
      chk("abort_run_res_valid", 128'(res_valid), 128'(1'b0));
      chk("abort_run_acc", mac_in3, 128'(0));
      run_job(1'b0, 3, rand128(), 0, 0, 1'b0, 32'h0, 32'h0, got);
      cfg_len     = '0;
      cfg_bias    = rand128();
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      chk("abort_done_pre", 128'(res_valid), 128'(1'b1));
      res_ready = 1'b1;
      abort     = 1'b1;
      step();
      res_ready = 1'b0;
      abort     = 1'b0;
      chk("abort_done_res_valid", 128'(res_valid), 128'(1'b0));
      chk("abort_done_acc", res_data, 128'(0));
      chk("abort_done_start_ready", 128'(start_ready), 128'(1'b1));
`endif

      run_job(1'b1, 20, rand128(), 0, 0, 1'b0, 32'h0, 32'h0, got);
      run_job(1'b0, 31, rand128(), 2, 1, 1'b0, 32'h0, 32'h0, got);

      for (int j = 0; j < 20; j++) begin
         run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)), rand128(), 2,
                 int'($urandom_range(0, 3)), 1'b0, 32'h0, 32'h0, got);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
